// File: rtl/cntr_pkg.sv
// Shared types for the up/down counter family.
// Mode encoding and direction constants.
package cntr_pkg;

    typedef enum logic {
        CNT_WRAP = 1'b0,
        CNT_SAT  = 1'b1
    } cnt_mode_e;

    localparam logic CNT_UP = 1'b0;
    localparam logic CNT_DN = 1'b1;

endpackage

// File: rtl/cntr_ud_mod.sv
// Parametrised up/down counter with load, enable,
// wrap/saturate boundaries and event pulses.
module cntr_ud_mod
    import cntr_pkg::*;
#(
    parameter int          WIDTH    = 3,
    parameter int unsigned MAX_VAL  = (1 << WIDTH) - 1,
    parameter bit          SATURATE = 1'b0
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             en,
    input  logic             up_down,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] bin_count,
    output logic             tc,
    output logic             wrap,
    output logic             sat_hit
);

    localparam longint unsigned LIM = (64'd1 << WIDTH) - 64'd1;
    localparam logic [WIDTH-1:0] MAXV = WIDTH'(MAX_VAL);
    localparam logic [WIDTH-1:0] ONE  = WIDTH'(1);
    localparam cnt_mode_e        MODE = SATURATE ? CNT_SAT : CNT_WRAP;

    generate
        if (WIDTH < 1 || WIDTH > 32) begin : g_bad_width
            $fatal(1, "cntr_ud_mod: WIDTH out of range 1..32");
        end
        if (MAX_VAL < 1 || longint'(MAX_VAL) > LIM) begin : g_bad_max
            $fatal(1, "cntr_ud_mod: MAX_VAL out of range 1..2**WIDTH-1");
        end
    endgenerate

    logic [WIDTH-1:0] next_cnt;
    logic             next_wrap;
    logic             next_sat;
    logic             at_top;
    logic             at_bot;

    assign at_top = (bin_count == MAXV);
    assign at_bot = (bin_count == '0);

    // Terminal count: the next enabled step would hit a boundary
    assign tc = en & (up_down ? at_bot : at_top);

    // Next-state selection: load > count step > hold
    always_comb begin
        next_cnt  = bin_count;
        next_wrap = 1'b0;
        next_sat  = 1'b0;
        if (load) begin
            next_cnt = (load_val > MAXV) ? MAXV : load_val;
        end else if (en) begin
            if (up_down == CNT_UP) begin
                if (!at_top) begin
                    next_cnt = bin_count + ONE;
                end else if (MODE == CNT_WRAP) begin
                    next_cnt  = '0;
                    next_wrap = 1'b1;
                end else begin
                    next_sat = 1'b1;
                end
            end else begin
                if (!at_bot) begin
                    next_cnt = bin_count - ONE;
                end else if (MODE == CNT_WRAP) begin
                    next_cnt  = MAXV;
                    next_wrap = 1'b1;
                end else begin
                    next_sat = 1'b1;
                end
            end
        end
    end

    // Count and event-pulse registers with synchronous reset
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            bin_count <= '0;
            wrap      <= 1'b0;
            sat_hit   <= 1'b0;
        end else begin
            bin_count <= next_cnt;
            wrap      <= next_wrap;
            sat_hit   <= next_sat;
        end
    end

endmodule

// File: tb/tb_cntr_ud_mod.sv
// Directed and randomised checks for cntr_ud_mod.
// Three instances: legacy 3-bit, mod-10 wrap, mod-10 saturate.
module tb_cntr_ud_mod;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       en = 1'b0;
    logic       up_down = 1'b0;
    logic       load = 1'b0;
    logic [3:0] lv = 4'd0;

    logic [2:0] cnt0;
    logic       tc0, wrap0, sat0;
    logic [3:0] cnt1;
    logic       tc1, wrap1, sat1;
    logic [3:0] cnt2;
    logic       tc2, wrap2, sat2;

    int n_chk = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    cntr_ud_mod u0 (
        .clk(clk), .reset_n(reset_n), .en(en), .up_down(up_down),
        .load(load), .load_val(lv[2:0]), .bin_count(cnt0),
        .tc(tc0), .wrap(wrap0), .sat_hit(sat0)
    );

    cntr_ud_mod #(.WIDTH(4), .MAX_VAL(9), .SATURATE(1'b0)) u1 (
        .clk(clk), .reset_n(reset_n), .en(en), .up_down(up_down),
        .load(load), .load_val(lv), .bin_count(cnt1),
        .tc(tc1), .wrap(wrap1), .sat_hit(sat1)
    );

    cntr_ud_mod #(.WIDTH(4), .MAX_VAL(9), .SATURATE(1'b1)) u2 (
        .clk(clk), .reset_n(reset_n), .en(en), .up_down(up_down),
        .load(load), .load_val(lv), .bin_count(cnt2),
        .tc(tc2), .wrap(wrap2), .sat_hit(sat2)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        int exp_c [9] = '{1, 2, 3, 4, 5, 6, 7, 0, 1};
        reset_n = 1'b0; en = 1'b1; load = 1'b1; lv = 4'd5;
        tick();
        tick();
        n_chk++;
        if (cnt0 !== 3'd0 || wrap0 !== 1'b0 || sat0 !== 1'b0) begin
            n_err++;
            $display("FAIL reset: cnt=%0d wrap=%b sat=%b, want 0 0 0",
                     cnt0, wrap0, sat0);
        end
        reset_n = 1'b1; load = 1'b0; up_down = 1'b0;
        for (int i = 0; i < 9; i++) begin
            tick();
            n_chk++;
            if (cnt0 !== 3'(exp_c[i]) || wrap0 !== (i == 7) ||
                tc0 !== (exp_c[i] == 7)) begin
                n_err++;
                $display("FAIL up_seq[%0d]: cnt=%0d wrap=%b tc=%b, want %0d %b %b",
                         i, cnt0, wrap0, tc0, exp_c[i], i == 7,
                         exp_c[i] == 7);
            end
        end
    endtask

    task automatic test_down_wrap;
        int exp_c [3] = '{0, 9, 8};
        load = 1'b1; lv = 4'd1; en = 1'b1;
        tick();
        n_chk++;
        if (cnt1 !== 4'd1) begin
            n_err++;
            $display("FAIL dn_load: cnt=%0d want 1", cnt1);
        end
        load = 1'b0; up_down = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_chk++;
            if (cnt1 !== 4'(exp_c[i]) || wrap1 !== (i == 1) ||
                tc1 !== (exp_c[i] == 0)) begin
                n_err++;
                $display("FAIL dn_seq[%0d]: cnt=%0d wrap=%b tc=%b, want %0d %b %b",
                         i, cnt1, wrap1, tc1, exp_c[i], i == 1,
                         exp_c[i] == 0);
            end
        end
    endtask

    task automatic test_saturate;
        load = 1'b1; lv = 4'd8; en = 1'b1; up_down = 1'b0;
        tick();
        load = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_chk++;
            if (cnt2 !== 4'd9 || sat2 !== (i > 0) || tc2 !== 1'b1 ||
                wrap2 !== 1'b0) begin
                n_err++;
                $display("FAIL sat_seq[%0d]: cnt=%0d sat=%b tc=%b wrap=%b, want 9 %b 1 0",
                         i, cnt2, sat2, tc2, wrap2, i > 0);
            end
        end
        up_down = 1'b1;
        tick();
        n_chk++;
        if (cnt2 !== 4'd8 || sat2 !== 1'b0) begin
            n_err++;
            $display("FAIL sat_turn: cnt=%0d sat=%b, want 8 0", cnt2, sat2);
        end
    endtask

    task automatic test_load_clamp;
        load = 1'b1; lv = 4'd14; en = 1'b1; up_down = 1'b0;
        tick();
        n_chk++;
        if (cnt1 !== 4'd9 || cnt2 !== 4'd9) begin
            n_err++;
            $display("FAIL clamp: cnt1=%0d cnt2=%0d, want 9 9", cnt1, cnt2);
        end
        n_chk++;
        if (wrap1 !== 1'b0 || sat2 !== 1'b0) begin
            n_err++;
            $display("FAIL clamp_pulse: wrap=%b sat=%b, want 0 0", wrap1, sat2);
        end
        lv = 4'd3;
        tick();
        lv = 4'd6;
        tick();
        n_chk++;
        if (cnt1 !== 4'd6) begin
            n_err++;
            $display("FAIL load_prio: cnt=%0d want 6", cnt1);
        end
    endtask

    task automatic test_hold_reset;
        load = 1'b1; lv = 4'd5; en = 1'b1; up_down = 1'b0;
        tick();
        load = 1'b0; en = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            n_chk++;
            if (cnt1 !== 4'd5 || tc1 !== 1'b0 || wrap1 !== 1'b0) begin
                n_err++;
                $display("FAIL hold[%0d]: cnt=%0d tc=%b wrap=%b, want 5 0 0",
                         i, cnt1, tc1, wrap1);
            end
        end
        en = 1'b1;
        tick();
        n_chk++;
        if (cnt1 !== 4'd6) begin
            n_err++;
            $display("FAIL resume: cnt=%0d want 6", cnt1);
        end
        reset_n = 1'b0;
        tick();
        n_chk++;
        if (cnt1 !== 4'd0 || cnt2 !== 4'd0) begin
            n_err++;
            $display("FAIL mid_reset: cnt1=%0d cnt2=%0d, want 0 0", cnt1, cnt2);
        end
        reset_n = 1'b1;
        tick();
        n_chk++;
        if (cnt1 !== 4'd1) begin
            n_err++;
            $display("FAIL post_reset: cnt=%0d want 1", cnt1);
        end
    endtask

    task automatic test_random;
        int  m [2];
        bit  mw [2];
        bit  ms [2];
        bit  etc;
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        m = '{0, 0};
        for (int c = 0; c < 2000; c++) begin
            en      = ($urandom_range(0, 3) != 0);
            up_down = 1'($urandom_range(0, 1));
            load    = ($urandom_range(0, 9) == 0);
            lv      = 4'($urandom_range(0, 15));
            #1;
            for (int s = 0; s < 2; s++) begin
                etc = en && (up_down ? (m[s] == 0) : (m[s] == 9));
                n_chk++;
                if ((s ? tc2 : tc1) !== etc) begin
                    n_err++;
                    $display("FAIL rnd_tc[%0d] s=%0d: tc=%b want %b",
                             c, s, s ? tc2 : tc1, etc);
                end
            end
            tick();
            for (int s = 0; s < 2; s++) begin
                mw[s] = 1'b0;
                ms[s] = 1'b0;
                if (load) begin
                    m[s] = (lv > 9) ? 9 : int'(lv);
                end else if (en && !up_down) begin
                    if (m[s] < 9) m[s] = m[s] + 1;
                    else if (s == 1) ms[s] = 1'b1;
                    else begin m[s] = 0; mw[s] = 1'b1; end
                end else if (en) begin
                    if (m[s] > 0) m[s] = m[s] - 1;
                    else if (s == 1) ms[s] = 1'b1;
                    else begin m[s] = 9; mw[s] = 1'b1; end
                end
            end
            n_chk++;
            if (cnt1 !== 4'(m[0]) || wrap1 !== mw[0] || sat1 !== ms[0]) begin
                n_err++;
                $display("FAIL rnd_wrap[%0d]: cnt=%0d wrap=%b sat=%b, want %0d %b %b",
                         c, cnt1, wrap1, sat1, m[0], mw[0], ms[0]);
            end
            n_chk++;
            if (cnt2 !== 4'(m[1]) || wrap2 !== mw[1] || sat2 !== ms[1]) begin
                n_err++;
                $display("FAIL rnd_sat[%0d]: cnt=%0d wrap=%b sat=%b, want %0d %b %b",
                         c, cnt2, wrap2, sat2, m[1], mw[1], ms[1]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_down_wrap();
        test_saturate();
        test_load_clamp();
        test_hold_reset();
        test_random();
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
